// File: rtl/ysyx_2022040010_sram_resp.sv
// ysyx_2022040010_sram_resp
//   Dual-ported, word-addressed 64-bit backing store answering the core's
//   instruction fetch port (isram_*) and load/store port (dsram_*).
//   Reads have one cycle of latency. After every reset the block zero-fills
//   the whole array before it accepts requests. It also records the first
//   out-of-range access and keeps access counters for the harness.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   isram_e      fetch enable
//   isram_addr   fetch byte address; bit 2 selects the 32-bit half
//   isram_rdata  registered fetch data (NOP 0x13 when out of range)
//   dsram_e      data access enable
//   dsram_we     1 = store, 0 = load
//   dsram_addr   data byte address; bits [2:0] are ignored
//   dsram_wdata  store doubleword
//   dsram_rdata  registered load data (0 when out of range)
//   init_done    high once the zero-fill has finished
//   addr_err     sticky out-of-range flag
//   err_addr     address of the first out-of-range access
//   ifetch_cnt / dload_cnt / dstore_cnt  wrapping 32-bit access counters
module ysyx_2022040010_sram_resp #(
  parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isram_e,
  input  logic [63:0] isram_addr,
  output logic [31:0] isram_rdata,
  input  logic        dsram_e,
  input  logic        dsram_we,
  input  logic [63:0] dsram_addr,
  input  logic [63:0] dsram_wdata,
  output logic [63:0] dsram_rdata,
  output logic        init_done,
  output logic        addr_err,
  output logic [63:0] err_addr,
  output logic [31:0] ifetch_cnt,
  output logic [31:0] dload_cnt,
  output logic [31:0] dstore_cnt
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  logic [63:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [AW-1:0] init_ptr_q, init_ptr_d;
  logic [31:0] irdata_q, irdata_d;
  logic [63:0] drdata_q, drdata_d;
  logic        err_q, err_d;
  logic [63:0] eaddr_q, eaddr_d;
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] lcnt_q, lcnt_d;
  logic [31:0] scnt_q, scnt_d;

  // Address decode: an address below the base wraps to a huge offset, so a
  // single check on the offset's high bits covers both ends of the window.
  logic [63:0]   i_off, d_off;
  logic [AW-1:0] i_idx, d_idx;
  logic          i_in, d_in;
  logic          unused_low_bits;

  assign i_off = isram_addr - ADDR_BASE;
  assign d_off = dsram_addr - ADDR_BASE;
  assign i_idx = i_off[AW+2:3];
  assign d_idx = d_off[AW+2:3];
  assign i_in  = (i_off[63:AW+3] == '0);
  assign d_in  = (d_off[63:AW+3] == '0);
  assign unused_low_bits = ^{i_off[2:0], d_off[2:0]};

  logic run;
  logic fetch_acc, load_acc, store_acc;
  logic i_fault, d_fault;
  logic [63:0] i_word;

  assign run       = (state_q == S_RUN);
  assign fetch_acc = run & isram_e;
  assign load_acc  = run & dsram_e & ~dsram_we;
  assign store_acc = run & dsram_e & dsram_we;
  assign i_fault   = fetch_acc & ~i_in;
  assign d_fault   = run & dsram_e & ~d_in;
  assign i_word    = mem[i_idx];

  // Single memory write port shared between the zero-fill and stores.
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [63:0]   mem_wdata;

  assign mem_we    = ~run | (store_acc & d_in);
  assign mem_widx  = run ? d_idx : init_ptr_q;
  assign mem_wdata = run ? dsram_wdata : '0;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    irdata_d   = irdata_q;
    drdata_d   = drdata_q;
    err_d      = err_q;
    eaddr_d    = eaddr_q;
    icnt_d     = icnt_q;
    lcnt_d     = lcnt_q;
    scnt_d     = scnt_q;

    if (!run) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == '1) state_d = S_RUN;
    end else begin
      if (fetch_acc) begin
        if (i_in) irdata_d = isram_addr[2] ? i_word[63:32] : i_word[31:0];
        else      irdata_d = 32'h0000_0013;
        icnt_d = icnt_q + 32'd1;
      end
      if (load_acc) begin
        drdata_d = d_in ? mem[d_idx] : '0;
        lcnt_d   = lcnt_q + 32'd1;
      end
      if (store_acc) scnt_d = scnt_q + 32'd1;
      // Data-port fault wins when both ports fault in the same cycle.
      if (!err_q && (d_fault || i_fault)) begin
        err_d   = 1'b1;
        eaddr_d = d_fault ? dsram_addr : isram_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      irdata_q   <= '0;
      drdata_q   <= '0;
      err_q      <= 1'b0;
      eaddr_q    <= '0;
      icnt_q     <= '0;
      lcnt_q     <= '0;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      irdata_q   <= irdata_d;
      drdata_q   <= drdata_d;
      err_q      <= err_d;
      eaddr_q    <= eaddr_d;
      icnt_q     <= icnt_d;
      lcnt_q     <= lcnt_d;
      scnt_q     <= scnt_d;
    end
  end

  // Reads above sample the array combinationally before this edge's write
  // lands, which gives read-before-write on a same-word fetch and store.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign isram_rdata = irdata_q;
  assign dsram_rdata = drdata_q;
  assign init_done   = run;
  assign addr_err    = err_q;
  assign err_addr    = eaddr_q;
  assign ifetch_cnt  = icnt_q;
  assign dload_cnt   = lcnt_q;
  assign dstore_cnt  = scnt_q;

endmodule

// File: tb/tb_ysyx_2022040010_sram_resp.sv
// Self-checking bench for ysyx_2022040010_sram_resp with DEPTH_LOG2 = 4.
// A behavioural model (array + edge count since reset) predicts every output;
// a negedge process compares it against the DUT each cycle, and directed
// scenarios add literal expectations.
module tb_ysyx_2022040010_sram_resp;

  localparam bit [63:0] BASE  = 64'h8000_0000;
  localparam int        WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        isram_e = 1'b0;
  logic [63:0] isram_addr = '0;
  logic [31:0] isram_rdata;
  logic        dsram_e = 1'b0;
  logic        dsram_we = 1'b0;
  logic [63:0] dsram_addr = '0;
  logic [63:0] dsram_wdata = '0;
  logic [63:0] dsram_rdata;
  logic        init_done;
  logic        addr_err;
  logic [63:0] err_addr;
  logic [31:0] ifetch_cnt, dload_cnt, dstore_cnt;

  ysyx_2022040010_sram_resp #(.ADDR_BASE(64'h8000_0000), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .isram_e(isram_e), .isram_addr(isram_addr), .isram_rdata(isram_rdata),
    .dsram_e(dsram_e), .dsram_we(dsram_we), .dsram_addr(dsram_addr),
    .dsram_wdata(dsram_wdata), .dsram_rdata(dsram_rdata),
    .init_done(init_done), .addr_err(addr_err), .err_addr(err_addr),
    .ifetch_cnt(ifetch_cnt), .dload_cnt(dload_cnt), .dstore_cnt(dstore_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  bit [63:0] m_mem [WORDS];
  int        m_edges;
  bit [31:0] m_ird;
  bit [63:0] m_drd;
  bit        m_err;
  bit [63:0] m_eaddr;
  bit [31:0] m_ic, m_lc, m_sc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input bit [63:0] a);
    return (a >= BASE) && (a < BASE + 64'd8 * WORDS);
  endfunction

  function automatic int widx(input bit [63:0] a);
    bit [63:0] o;
    o = (a - BASE) >> 3;
    return int'(o);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
    m_edges = 0; m_ird = '0; m_drd = '0; m_err = 1'b0; m_eaddr = '0;
    m_ic = '0; m_lc = '0; m_sc = '0;
  endtask

  // Called just after a rising edge with rst high; applies the request that
  // the edge sampled.
  task automatic m_step();
    bit [63:0] w;
    m_edges++;
    if (m_edges <= WORDS) begin
      m_mem[m_edges-1] = '0;
      return;
    end
    if (isram_e) begin
      if (in_rng(isram_addr)) begin
        w = m_mem[widx(isram_addr)];
        m_ird = isram_addr[2] ? w[63:32] : w[31:0];
      end else m_ird = 32'h13;
      m_ic++;
    end
    if (dsram_e && !dsram_we) begin
      m_drd = in_rng(dsram_addr) ? m_mem[widx(dsram_addr)] : 64'h0;
      m_lc++;
    end
    if (!m_err) begin
      if (dsram_e && !in_rng(dsram_addr)) begin
        m_err = 1'b1; m_eaddr = dsram_addr;
      end else if (isram_e && !in_rng(isram_addr)) begin
        m_err = 1'b1; m_eaddr = isram_addr;
      end
    end
    if (dsram_e && dsram_we) begin
      if (in_rng(dsram_addr)) m_mem[widx(dsram_addr)] = dsram_wdata;
      m_sc++;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("isram_rdata", {32'h0, isram_rdata}, {32'h0, m_ird});
      chk("dsram_rdata", dsram_rdata, m_drd);
      chk("init_done", {63'h0, init_done}, {63'h0, (m_edges >= WORDS)});
      chk("addr_err", {63'h0, addr_err}, {63'h0, m_err});
      chk("err_addr", err_addr, m_eaddr);
      chk("ifetch_cnt", {32'h0, ifetch_cnt}, {32'h0, m_ic});
      chk("dload_cnt", {32'h0, dload_cnt}, {32'h0, m_lc});
      chk("dstore_cnt", {32'h0, dstore_cnt}, {32'h0, m_sc});
    end
  end

  // Drive one request starting just after a falling edge; returns at the next
  // falling edge with the model advanced.
  task automatic cyc(input bit ie, input bit [63:0] ia, input bit de, input bit dwe,
                     input bit [63:0] da, input bit [63:0] dwd);
    isram_e = ie; isram_addr = ia;
    dsram_e = de; dsram_we = dwe; dsram_addr = da; dsram_wdata = dwd;
    @(posedge clk);
    if (rst) m_step();
    @(negedge clk);
  endtask

  function automatic bit [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return BASE - 64'd8;
    if (r == 1) return BASE + 64'd8 * WORDS + 64'($urandom_range(0, 15));
    return BASE + 64'($urandom_range(0, 8 * WORDS - 1));
  endfunction

  task automatic rand_cyc();
    cyc(1'($urandom), rand_addr(), 1'($urandom), 1'($urandom), rand_addr(),
        {$urandom, $urandom});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ird"}, {32'h0, isram_rdata}, 64'h0);
    chk({tag, "_drd"}, dsram_rdata, 64'h0);
    chk({tag, "_done"}, {63'h0, init_done}, 64'h0);
    chk({tag, "_err"}, {63'h0, addr_err}, 64'h0);
    chk({tag, "_eaddr"}, err_addr, 64'h0);
    chk({tag, "_cnt"}, {ifetch_cnt, dload_cnt ^ dstore_cnt}, 64'h0);
    chk({tag, "_cnt2"}, {32'h0, dload_cnt | dstore_cnt}, 64'h0);
  endtask

  initial begin
    m_reset();
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("rst0");
    rst = 1'b1;

    // Zero-fill: a fetch during INIT must be ignored.
    for (int k = 1; k <= WORDS; k++) begin
      cyc(1'b1, BASE, 1'b0, 1'b0, '0, '0);
      if (k == WORDS - 1) chk("init_done_e15", {63'h0, init_done}, 64'h0);
    end
    chk("init_done_e16", {63'h0, init_done}, 64'h1);
    chk("init_fetch_rd", {32'h0, isram_rdata}, 64'h0);
    chk("init_fetch_cnt", {32'h0, ifetch_cnt}, 64'h0);

    // Store then load back; fetch both halves.
    cyc(1'b0, '0, 1'b1, 1'b1, BASE + 64'h8, 64'h1122_3344_5566_7788);
    cyc(1'b0, '0, 1'b1, 1'b0, BASE + 64'h8, '0);
    chk("load_back", dsram_rdata, 64'h1122_3344_5566_7788);
    cyc(1'b1, BASE + 64'hC, 1'b0, 1'b0, '0, '0);
    chk("fetch_hi", {32'h0, isram_rdata}, 64'h1122_3344);
    cyc(1'b1, BASE + 64'h8, 1'b0, 1'b0, '0, '0);
    chk("fetch_lo", {32'h0, isram_rdata}, 64'h5566_7788);

    // Read-before-write on same word.
    cyc(1'b1, BASE + 64'h10, 1'b1, 1'b1, BASE + 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    chk("rbw_old", {32'h0, isram_rdata}, 64'h0);
    cyc(1'b1, BASE + 64'h10, 1'b0, 1'b0, '0, '0);
    chk("rbw_new", {32'h0, isram_rdata}, 64'hCAFE_F00D);

    // Out-of-range traffic.
    cyc(1'b0, '0, 1'b1, 1'b0, 64'h7FFF_FFF8, '0);
    chk("oor_load_rd", dsram_rdata, 64'h0);
    chk("oor_err", {63'h0, addr_err}, 64'h1);
    chk("oor_eaddr", err_addr, 64'h7FFF_FFF8);
    cyc(1'b0, '0, 1'b1, 1'b1, BASE + 64'h80, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("oor_store_eaddr", err_addr, 64'h7FFF_FFF8);
    cyc(1'b1, BASE + 64'h80, 1'b0, 1'b0, '0, '0);
    chk("oor_fetch_nop", {32'h0, isram_rdata}, 64'h13);

    // Mid-run asynchronous reset after a nonzero store.
    cyc(1'b0, '0, 1'b1, 1'b1, BASE + 64'h20, 64'h5A5A_0000_1234_5678);
    #2 rst = 1'b0;
    m_reset();
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    // Requests during the refill are ignored.
    for (int k = 0; k < WORDS; k++) rand_cyc();
    chk("reinit_done", {63'h0, init_done}, 64'h1);

    // 3 fetches, 2 loads, 1 store, then 5 idle cycles.
    cyc(1'b0, '0, 1'b1, 1'b1, BASE + 64'h30, 64'h0123_4567_89AB_CDEF);
    cyc(1'b1, BASE + 64'h20, 1'b1, 1'b0, BASE + 64'h20, '0);
    chk("rezeroed_load", dsram_rdata, 64'h0);
    cyc(1'b1, BASE + 64'h30, 1'b1, 1'b0, BASE + 64'h30, '0);
    cyc(1'b1, BASE + 64'h34, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++)
      cyc(1'b0, rand_addr(), 1'b0, 1'($urandom), rand_addr(), {$urandom, $urandom});
    chk("hold_ird", {32'h0, isram_rdata}, 64'h0123_4567);
    chk("hold_drd", dsram_rdata, 64'h0123_4567_89AB_CDEF);
    chk("cnt_fetch", {32'h0, ifetch_cnt}, 64'd3);
    chk("cnt_load", {32'h0, dload_cnt}, 64'd2);
    chk("cnt_store", {32'h0, dstore_cnt}, 64'd1);
    chk("no_err_yet", {63'h0, addr_err}, 64'h0);

    // Both ports fault together: data address is captured.
    cyc(1'b1, 64'h9000_0000, 1'b1, 1'b0, 64'h7000_0000, '0);
    chk("dual_fault_eaddr", err_addr, 64'h7000_0000);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) rand_cyc();

    // Reset again: counters and error clear, then a random run with a fresh
    // error capture.
    #2 rst = 1'b0;
    m_reset();
    #1 chk_all_zero("rst_end");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < WORDS + 200; k++) rand_cyc();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
